// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_pkg
//
// Shared definitions for the multi-cycle MIPS control unit and the datapath
// it drives: the FSM state encoding, the opcode values it recognises, the
// ALU operation codes and the mux-select encodings for ALU operand B and the
// PC source.
// -----------------------------------------------------------------------------
package multicycle_control_pkg;

    // FSM states. The numeric values are visible on state_o, so they are fixed.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JAL       = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    // Opcode field values (6-bit MIPS encoding).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operation codes; zero-extended to the configured alu_op width.
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_LUI    = 4'b0010;
    localparam logic [3:0] ALU_AND    = 4'b0011;
    localparam logic [3:0] ALU_SUB_EQ = 4'b0110;
    localparam logic [3:0] ALU_SUB_NE = 4'b0111;
    localparam logic [3:0] ALU_FUNCT  = 4'b1111;  // ALU decodes the funct field

    // ALU operand B select.
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// -----------------------------------------------------------------------------
// mc_output_decode
//
// Purely combinational mapping from (state, latched opcode, memory ready) to
// every datapath control signal. Anything not driven for a state stays 0.
//
// Ports:
//   state          in   current FSM state
//   op_q           in   opcode latched in DECODE
//   mem_ready      in   memory completed the current access this cycle
//   pc_write .. illegal   out  datapath controls (see multicycle_control)
// -----------------------------------------------------------------------------
module mc_output_decode
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int ALU_OP_WIDTH = 4
) (
    input  state_t                   state,
    input  logic [OPCODE_WIDTH-1:0]  op_q,
    input  logic                     mem_ready,
    output logic                     pc_write,
    output logic                     pc_write_cond,
    output logic                     branch_ne,
    output logic                     ir_write,
    output logic                     i_or_d,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     reg_dst,
    output logic                     mem_to_reg,
    output logic                     reg_write,
    output logic                     link,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               pc_src,
    output logic [ALU_OP_WIDTH-1:0]  alu_op,
    output logic                     instr_done,
    output logic                     illegal
);

    logic       is_rtype;
    logic       is_bne;
    logic [3:0] exec_code;

    assign is_rtype = (op_q == OPCODE_WIDTH'(OP_RTYPE));
    assign is_bne   = (op_q == OPCODE_WIDTH'(OP_BNE));

    // ALU operation used in EXECUTE for R-type and immediate instructions.
    always_comb begin
        exec_code = ALU_ADD;
        case (op_q)
            OPCODE_WIDTH'(OP_RTYPE): exec_code = ALU_FUNCT;
            OPCODE_WIDTH'(OP_ADDI):  exec_code = ALU_ADD;
            OPCODE_WIDTH'(OP_ORI):   exec_code = ALU_OR;
            OPCODE_WIDTH'(OP_LUI):   exec_code = ALU_LUI;
            OPCODE_WIDTH'(OP_ANDI):  exec_code = ALU_AND;
            default:                 exec_code = ALU_ADD;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        link          = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_SRC_ALU;
        alu_op        = ALU_OP_WIDTH'(ALU_ADD);
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (state)
            S_FETCH: begin
                // Read strobe is held through wait cycles; PC and IR only
                // capture in the cycle the memory returns the word.
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                pc_src    = PC_SRC_ALU;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                alu_src_b = SRC_B_IMM_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = is_rtype ? SRC_B_REG : SRC_B_IMM;
                alu_op    = ALU_OP_WIDTH'(exec_code);
            end
            S_ALU_WB: begin
                reg_dst    = is_rtype;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_REG;
                alu_op        = ALU_OP_WIDTH'(is_bne ? ALU_SUB_NE : ALU_SUB_EQ);
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_ALUOUT;
                branch_ne     = is_bne;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                reg_write  = 1'b1;
                link       = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                // IDLE and unused encodings drive nothing.
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle control FSM for the shared-memory MIPS datapath. Sequences
// fetch / decode / execute / memory / writeback, stalls on the memory ready
// handshake and parks in TRAP on an illegal opcode until reset.
//
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   opcode_i          opcode field from the IR, sampled only in DECODE
//   mem_ready_i       memory completed the current read/write this cycle
//   pc_write_o ..     datapath enables and mux selects (from mc_output_decode)
//   instr_done_o      one-cycle pulse in the final cycle of an instruction
//   illegal_o         high while in TRAP
//   state_o           current state for debug
//
// Memory handshake: a strobe (mem_read_o / mem_write_o) is an open request
// that stays constant until a cycle in which mem_ready_i is high; that cycle
// completes the access and the FSM moves on at the following clock edge.
// -----------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int ALU_OP_WIDTH = 4,
    parameter int ENABLE_JAL   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_WIDTH-1:0]  opcode_i,
    input  logic                     mem_ready_i,
    output logic                     pc_write_o,
    output logic                     pc_write_cond_o,
    output logic                     branch_ne_o,
    output logic                     ir_write_o,
    output logic                     i_or_d_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic                     reg_dst_o,
    output logic                     mem_to_reg_o,
    output logic                     reg_write_o,
    output logic                     link_o,
    output logic                     alu_src_a_o,
    output logic [1:0]               alu_src_b_o,
    output logic [1:0]               pc_src_o,
    output logic [ALU_OP_WIDTH-1:0]  alu_op_o,
    output logic                     instr_done_o,
    output logic                     illegal_o,
    output logic [3:0]               state_o
);

    state_t                   state_q;
    state_t                   decode_next;
    logic [OPCODE_WIDTH-1:0]  op_q;

    // Dispatch target out of DECODE, from the opcode currently on the IR.
    always_comb begin
        decode_next = S_TRAP;
        case (opcode_i)
            OPCODE_WIDTH'(OP_LW),
            OPCODE_WIDTH'(OP_SW):    decode_next = S_MEM_ADDR;
            OPCODE_WIDTH'(OP_RTYPE),
            OPCODE_WIDTH'(OP_ADDI),
            OPCODE_WIDTH'(OP_ORI),
            OPCODE_WIDTH'(OP_LUI),
            OPCODE_WIDTH'(OP_ANDI):  decode_next = S_EXECUTE;
            OPCODE_WIDTH'(OP_BEQ),
            OPCODE_WIDTH'(OP_BNE):   decode_next = S_BRANCH;
            OPCODE_WIDTH'(OP_J):     decode_next = S_JUMP;
            OPCODE_WIDTH'(OP_JAL):   decode_next = (ENABLE_JAL != 0) ? S_JAL : S_TRAP;
            default:                 decode_next = S_TRAP;
        endcase
    end

    // Async reset drops straight to IDLE, so every strobe (which decodes
    // from the state) falls without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE:      state_q <= S_FETCH;
                S_FETCH:     if (mem_ready_i) state_q <= S_DECODE;
                S_DECODE: begin
                    op_q    <= opcode_i;
                    state_q <= decode_next;
                end
                // Only LW and SW reach MEM_ADDR.
                S_MEM_ADDR:  state_q <= (op_q == OPCODE_WIDTH'(OP_SW)) ? S_MEM_WRITE
                                                                       : S_MEM_READ;
                S_MEM_READ:  if (mem_ready_i) state_q <= S_MEM_WB;
                S_MEM_WB:    state_q <= S_FETCH;
                S_MEM_WRITE: if (mem_ready_i) state_q <= S_FETCH;
                S_EXECUTE:   state_q <= S_ALU_WB;
                S_ALU_WB:    state_q <= S_FETCH;
                S_BRANCH:    state_q <= S_FETCH;
                S_JUMP:      state_q <= S_FETCH;
                S_JAL:       state_q <= S_FETCH;
                S_TRAP:      state_q <= S_TRAP;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o = state_q;

    mc_output_decode #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_output_decode (
        .state         (state_q),
        .op_q          (op_q),
        .mem_ready     (mem_ready_i),
        .pc_write      (pc_write_o),
        .pc_write_cond (pc_write_cond_o),
        .branch_ne     (branch_ne_o),
        .ir_write      (ir_write_o),
        .i_or_d        (i_or_d_o),
        .mem_read      (mem_read_o),
        .mem_write     (mem_write_o),
        .reg_dst       (reg_dst_o),
        .mem_to_reg    (mem_to_reg_o),
        .reg_write     (reg_write_o),
        .link          (link_o),
        .alu_src_a     (alu_src_a_o),
        .alu_src_b     (alu_src_b_o),
        .pc_src        (pc_src_o),
        .alu_op        (alu_op_o),
        .instr_done    (instr_done_o),
        .illegal       (illegal_o)
    );

endmodule
